// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: FSM state encodings, oversample ratio,
// baud divisor and parity computation.
package uart_pkg;

    localparam int OVS = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Rounded clk/(baud*16), never below 1 so the tick generator always advances.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * OVS) / 2) / (baud * OVS);
        return (d < 1) ? 1 : d;
    endfunction

    // Zero padding above the payload does not change the XOR, so one 8-bit form serves 5..8 bits.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x-oversample tick: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_cfg.sv
// Full-duplex UART with independent TX and RX engines sharing one oversample tick.
// state     | meaning
// TX_IDLE   | line high, tx_ready=1          TX_START/DATA/PARITY | 16 ticks per bit
// TX_STOP   | line high for STOP_BITS*16 ticks
// RX_IDLE   | wait for rx_s low              RX_START | confirm start at half bit
// RX_DATA/PARITY/STOP | sample mid-bit      RX_BREAK | framing error, wait for line high
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int         DIV       = calc_div(CLK_HZ, BAUD);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * OVS - 1);
    localparam logic [3:0] BIT_LAST  = 4'(OVS - 1);
    localparam logic [3:0] HALF_LAST = 4'(OVS / 2 - 1);
    localparam logic [2:0] DB_LAST   = 3'(DATA_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    logic tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    tx_state_t              tx_state, tx_state_nx;
    logic [4:0]             tx_cnt, tx_cnt_nx;
    logic [2:0]             tx_idx, tx_idx_nx;
    logic [DATA_BITS-1:0]   tx_sh, tx_sh_nx;
    logic                   tx_par, tx_par_nx;
    logic                   tx_bit, tx_bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_sh    <= tx_sh_nx;
            tx_par   <= tx_par_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_sh_nx    = tx_sh;
        tx_par_nx   = tx_par;
        tx_bit      = 1'b1;
        tx_bit_end  = tick && (tx_cnt == {1'b0, BIT_LAST});
        if (tx_state != TX_IDLE && tick)
            tx_cnt_nx = tx_cnt + 5'd1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_nx = TX_START;
                    tx_cnt_nx   = '0;
                    tx_idx_nx   = '0;
                    tx_sh_nx    = tx_data;
                    tx_par_nx   = parity_bit(8'(tx_data), ODD);
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_bit_end) begin
                    tx_state_nx = TX_DATA;
                    tx_cnt_nx   = '0;
                end
            end
            TX_DATA: begin
                tx_bit = tx_sh[0];
                if (tx_bit_end) begin
                    tx_cnt_nx = '0;
                    if (tx_idx == DB_LAST) begin
                        tx_state_nx = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_idx_nx = tx_idx + 3'd1;
                        tx_sh_nx  = tx_sh >> 1;
                    end
                end
            end
            TX_PARITY: begin
                tx_bit = tx_par;
                if (tx_bit_end) begin
                    tx_state_nx = TX_STOP;
                    tx_cnt_nx   = '0;
                end
            end
            TX_STOP: begin
                if (tick && tx_cnt == STOP_LAST) begin
                    tx_state_nx = TX_IDLE;
                    tx_cnt_nx   = '0;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    assign tx       = tx_bit;
    assign tx_ready = (tx_state == TX_IDLE);
    assign tx_busy  = ~tx_ready;

    // Sync flops reset high so a reset never looks like a start bit.
    logic rx_m, rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_state_t              rx_state, rx_state_nx;
    logic [3:0]             rx_cnt, rx_cnt_nx;
    logic [2:0]             rx_idx, rx_idx_nx;
    logic [DATA_BITS-1:0]   rx_sh, rx_sh_nx;
    logic                   rx_par, rx_par_nx;
    logic                   rx_done, rx_bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_sh         <= '0;
            rx_par        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_sh    <= rx_sh_nx;
            rx_par   <= rx_par_nx;
            rx_valid <= rx_done;
            if (rx_done) begin
                rx_data       <= rx_sh;
                rx_frame_err  <= ~rx_s;
                rx_parity_err <= (PARITY_EN != 0) &&
                                 (rx_par != parity_bit(8'(rx_sh), ODD));
            end
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_idx_nx   = rx_idx;
        rx_sh_nx    = rx_sh;
        rx_par_nx   = rx_par;
        rx_done     = 1'b0;
        rx_bit_end  = tick && (rx_cnt == BIT_LAST);
        if (rx_state != RX_IDLE && rx_state != RX_BREAK && tick)
            rx_cnt_nx = rx_cnt + 4'd1;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_nx = RX_START;
                    rx_cnt_nx   = '0;
                end
            end
            RX_START: begin
                if (tick && rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_idx_nx   = '0;
                    rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_nx = '0;
                    rx_sh_nx  = {rx_s, rx_sh[DATA_BITS-1:1]};
                    if (rx_idx == DB_LAST)
                        rx_state_nx = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    else
                        rx_idx_nx = rx_idx + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_nx   = '0;
                    rx_par_nx   = rx_s;
                    rx_state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_nx   = '0;
                    rx_done     = 1'b1;
                    rx_state_nx = rx_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_s)
                    rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

endmodule
